// File: rtl/key_ctr_bank.sv
// Multi-slot key/counter register bank feeding the AES core.
// Each slot is loaded word by word and carries a completeness mask and a sticky counter-wrap flag.
module key_ctr_bank #(
    parameter int WORDS     = 4,
    parameter int WORD_SIZE = 32,
    parameter int SLOTS     = 4,
    parameter int CTR_BITS  = 32,
    parameter int SWAP      = 1,
    localparam int SLOT_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1,
    localparam int IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int BLOCK    = WORDS * WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SLOT_W-1:0]    wslot,
    input  logic [IDX_W-1:0]     widx,
    input  logic                 wen,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic                 clr,
    input  logic                 inc,
    input  logic [SLOT_W-1:0]    rslot,
    output logic [BLOCK-1:0]     rdata,
    output logic                 rvalid,
    output logic                 rwrap
);

    localparam int WORD_BYTES = WORD_SIZE / 8;

    logic [WORD_SIZE-1:0] word_in;
    logic [WORDS-1:0]     word_sel;
    logic                 slot_ok;
    logic                 idx_ok;
    logic                 wr_any;

    logic [SLOTS-1:0][BLOCK-1:0] data_all;
    logic [SLOTS-1:0]            valid_all;
    logic [SLOTS-1:0]            wrap_all;

    logic [SLOT_W-1:0] rslot_reg;
    logic [BLOCK-1:0]  rdata_reg, rdata_next;
    logic              rvalid_reg, rvalid_next;
    logic              rwrap_reg, rwrap_next;

    assign slot_ok = (int'(wslot) < SLOTS);
    assign idx_ok  = (int'(widx) < WORDS);
    assign wr_any  = wen && idx_ok;

    // Optional little-endian to big-endian byte reversal of the bus word.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_byte
            if (SWAP != 0) begin : g_swap
                assign word_in[gi*8 +: 8] = wdata[(WORD_BYTES-1-gi)*8 +: 8];
            end else begin : g_pass
                assign word_in[gi*8 +: 8] = wdata[gi*8 +: 8];
            end
        end

        for (gi = 0; gi < WORDS; gi++) begin : g_word_sel
            assign word_sel[gi] = wr_any && (widx == IDX_W'(gi));
        end
    endgenerate

    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            logic [BLOCK-1:0]    data_reg, data_next;
            logic [WORDS-1:0]    mask_reg, mask_next;
            logic                wrap_reg, wrap_next;
            logic                hit;
            logic [CTR_BITS-1:0] ctr_cur;

            assign hit     = slot_ok && (wslot == SLOT_W'(gi));
            assign ctr_cur = data_reg[CTR_BITS-1:0];

            // Priority clr > wen > inc; losers are simply dropped.
            always_comb begin
                data_next = data_reg;
                mask_next = mask_reg;
                wrap_next = wrap_reg;
                if (hit && clr) begin
                    data_next = '0;
                    mask_next = '0;
                    wrap_next = 1'b0;
                end else if (hit && wr_any) begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (word_sel[k]) begin
                            data_next[(WORDS-1-k)*WORD_SIZE +: WORD_SIZE] = word_in;
                            mask_next[k] = 1'b1;
                        end
                    end
                end else if (hit && inc && (&mask_reg)) begin
                    data_next[CTR_BITS-1:0] = ctr_cur + 1'b1;
                    if (&ctr_cur) begin
                        wrap_next = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg <= '0;
                    mask_reg <= '0;
                    wrap_reg <= 1'b0;
                end else begin
                    data_reg <= data_next;
                    mask_reg <= mask_next;
                    wrap_reg <= wrap_next;
                end
            end

            assign data_all[gi]  = data_reg;
            assign valid_all[gi] = &mask_reg;
            assign wrap_all[gi]  = wrap_reg;
        end
    endgenerate

    // Read mux works on the slot selected last cycle against the already-updated state.
    always_comb begin
        rdata_next  = '0;
        rvalid_next = 1'b0;
        rwrap_next  = 1'b0;
        for (int s = 0; s < SLOTS; s++) begin
            if (rslot_reg == SLOT_W'(s)) begin
                rdata_next  = data_all[s];
                rvalid_next = valid_all[s];
                rwrap_next  = wrap_all[s];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rslot_reg  <= '0;
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
            rwrap_reg  <= 1'b0;
        end else begin
            rslot_reg  <= rslot;
            rdata_reg  <= rdata_next;
            rvalid_reg <= rvalid_next;
            rwrap_reg  <= rwrap_next;
        end
    end

    assign rdata  = rdata_reg;
    assign rvalid = rvalid_reg;
    assign rwrap  = rwrap_reg;

endmodule

// File: tb/tb_key_ctr_bank.sv
// Randomized plus directed bench for key_ctr_bank with a queue-based scoreboard
// fed by an abstract slot model.
module tb_key_ctr_bank;

    localparam int WORDS      = 4;
    localparam int WORD_SIZE  = 32;
    localparam int SLOTS      = 4;
    localparam int CTR_BITS   = 32;
    localparam int SWAP       = 1;
    localparam int SLOT_W     = 2;
    localparam int IDX_W      = 2;
    localparam int BLOCK      = WORDS * WORD_SIZE;
    localparam int WORD_BYTES = WORD_SIZE / 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [SLOT_W-1:0]    wslot = '0;
    logic [IDX_W-1:0]     widx = '0;
    logic                 wen = 1'b0;
    logic [WORD_SIZE-1:0] wdata = '0;
    logic                 clr = 1'b0;
    logic                 inc = 1'b0;
    logic [SLOT_W-1:0]    rslot = '0;
    logic [BLOCK-1:0]     rdata;
    logic                 rvalid;
    logic                 rwrap;

    key_ctr_bank #(
        .WORDS(WORDS), .WORD_SIZE(WORD_SIZE), .SLOTS(SLOTS),
        .CTR_BITS(CTR_BITS), .SWAP(SWAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wslot(wslot), .widx(widx), .wen(wen),
        .wdata(wdata), .clr(clr), .inc(inc), .rslot(rslot),
        .rdata(rdata), .rvalid(rvalid), .rwrap(rwrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             edge_no;
        logic [BLOCK-1:0] d;
        bit             v;
        bit             w;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   ec = 0;
    int   cur_rs = 0;

    logic [BLOCK-1:0] m_data [SLOTS];
    bit               m_wr   [SLOTS][WORDS];
    bit               m_wrap [SLOTS];
    logic [BLOCK-1:0] ctr_mask;

    function automatic bit m_valid(int s);
        for (int k = 0; k < WORDS; k++)
            if (!m_wr[s][k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_reset();
        for (int s = 0; s < SLOTS; s++) begin
            m_data[s] = '0;
            m_wrap[s] = 1'b0;
            for (int k = 0; k < WORDS; k++) m_wr[s][k] = 1'b0;
        end
    endtask

    task automatic compare(string name, logic [BLOCK-1:0] ed, bit ev, bit ew);
        checks++;
        if (rdata !== ed || rvalid !== ev || rwrap !== ew) begin
            errors++;
            $display("FAIL %s: got data=%h valid=%b wrap=%b, expected data=%h valid=%b wrap=%b",
                     name, rdata, rvalid, rwrap, ed, ev, ew);
        end
    endtask

    // Monitor: the output visible after edge ec is compared with the entry tagged for that edge.
    always @(posedge clk) begin
        ec = ec + 1;
        #1;
        if (rst_n) begin
            while (sbq.size() > 0 && sbq[0].edge_no <= ec) begin
                exp_t e;
                e = sbq.pop_front();
                if (e.edge_no == ec) compare("scoreboard", e.d, e.v, e.w);
            end
        end
    end

    // Drive one cycle of stimulus and advance the model to the state after the sampling edge.
    task automatic step(int s, int idx, bit w, logic [WORD_SIZE-1:0] d, bit c, bit i, int rs);
        exp_t e;
        logic [BLOCK-1:0] lo;
        int pos;
        @(negedge clk);
        wslot = SLOT_W'(s);
        widx  = IDX_W'(idx);
        wen   = w;
        wdata = d;
        clr   = c;
        inc   = i;
        rslot = SLOT_W'(rs);
        cur_rs = rs;
        if (s < SLOTS) begin
            if (c) begin
                m_data[s] = '0;
                m_wrap[s] = 1'b0;
                for (int k = 0; k < WORDS; k++) m_wr[s][k] = 1'b0;
            end else if (w && idx < WORDS) begin
                for (int b = 0; b < WORD_BYTES; b++) begin
                    pos = (WORDS - 1 - idx) * WORD_SIZE
                        + 8 * ((SWAP != 0) ? (WORD_BYTES - 1 - b) : b);
                    m_data[s][pos +: 8] = d[8*b +: 8];
                end
                m_wr[s][idx] = 1'b1;
            end else if (i && m_valid(s)) begin
                lo = m_data[s] & ctr_mask;
                if (lo == ctr_mask) begin
                    m_wrap[s] = 1'b1;
                    lo = '0;
                end else begin
                    lo = lo + 1;
                end
                m_data[s] = (m_data[s] & ~ctr_mask) | lo;
            end
        end
        e.edge_no = ec + 2;
        e.d = m_data[rs];
        e.v = m_valid(rs);
        e.w = m_wrap[rs];
        sbq.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 1'b0, '0, 1'b0, 1'b0, cur_rs);
    endtask

    // Idle one cycle, then check the outputs against a value written out by hand.
    task automatic chk(string name, logic [BLOCK-1:0] ed, bit ev, bit ew);
        idle();
        @(posedge clk);
        #2;
        compare(name, ed, ev, ew);
    endtask

    task automatic wr(int s, int idx, logic [WORD_SIZE-1:0] d, int rs);
        step(s, idx, 1'b1, d, 1'b0, 1'b0, rs);
    endtask

    task automatic do_inc(int s, int rs);
        step(s, 0, 1'b0, '0, 1'b0, 1'b1, rs);
    endtask

    initial begin
        ctr_mask = (BLOCK'(1) << CTR_BITS) - 1;
        m_reset();

        // Reset defaults, before and across clock edges.
        #1;
        compare("reset_async", '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        compare("reset_held", '0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Full load of slot 2 with byte swap.
        wr(2, 0, 32'h00112233, 2);
        wr(2, 1, 32'h44556677, 2);
        wr(2, 2, 32'h8899AABB, 2);
        chk("load_3of4", 128'h33221100_77665544_BBAA9988_00000000, 1'b0, 1'b0);
        wr(2, 3, 32'hCCDDEEFF, 2);
        chk("load_full", 128'h33221100_77665544_BBAA9988_FFEEDDCC, 1'b1, 1'b0);

        // Partial load of slot 1, completion, then rewrite.
        wr(1, 0, 32'h11111111, 1);
        wr(1, 1, 32'h22222222, 1);
        wr(1, 3, 32'h44444444, 1);
        chk("partial", 128'h11111111_22222222_00000000_44444444, 1'b0, 1'b0);
        wr(1, 2, 32'h33333333, 1);
        chk("partial_done", 128'h11111111_22222222_33333333_44444444, 1'b1, 1'b0);
        wr(1, 0, 32'h55555555, 1);
        chk("rewrite", 128'h55555555_22222222_33333333_44444444, 1'b1, 1'b0);

        // Counter wrap on slot 0.
        wr(0, 0, 32'hA5A5A5A5, 0);
        wr(0, 1, 32'hA5A5A5A5, 0);
        wr(0, 2, 32'hA5A5A5A5, 0);
        wr(0, 3, 32'hFEFFFFFF, 0);
        chk("ctr_load", 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_FFFFFFFE, 1'b1, 1'b0);
        do_inc(0, 0);
        chk("ctr_inc1", 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_FFFFFFFF, 1'b1, 1'b0);
        do_inc(0, 0);
        chk("ctr_wrap", 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_00000000, 1'b1, 1'b1);
        do_inc(0, 0);
        chk("ctr_sticky", 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_00000001, 1'b1, 1'b1);

        // Priority clr > wen > inc, then inc on an unloaded slot.
        step(0, 1, 1'b1, 32'h12345678, 1'b1, 1'b1, 0);
        chk("prio_clr", '0, 1'b0, 1'b0);
        do_inc(0, 0);
        chk("inc_invalid", '0, 1'b0, 1'b0);
        wr(0, 0, 32'h01010101, 0);
        wr(0, 1, 32'h01010101, 0);
        wr(0, 2, 32'h01010101, 0);
        wr(0, 3, 32'h10000000, 0);
        step(0, 1, 1'b1, 32'h0F0F0F0F, 1'b0, 1'b1, 0);
        chk("prio_wen", 128'h01010101_0F0F0F0F_01010101_00000010, 1'b1, 1'b0);

        // Isolation: traffic on slot 3 while reading slots 0..2.
        for (int n = 0; n < 24; n++)
            step(3, n % WORDS, 1'b1, $urandom, (n % 7) == 6, 1'b0, n % 3);
        step(0, 0, 1'b0, '0, 1'b0, 1'b0, 2);
        chk("isolate_s2", 128'h33221100_77665544_BBAA9988_FFEEDDCC, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a load.
        step(3, 0, 1'b0, '0, 1'b1, 1'b0, 3);
        wr(3, 0, 32'hDEADBEEF, 3);
        wr(3, 1, 32'hCAFEF00D, 3);
        chk("midload_pre", 128'hEFBEADDE_0DF0FECA_00000000_00000000, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        compare("midload_async", '0, 1'b0, 1'b0);
        sbq.delete();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        compare("midload_held", '0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        wr(3, 2, 32'h01234567, 3);
        wr(3, 3, 32'h89ABCDEF, 3);
        chk("midload_after", 128'h00000000_00000000_67452301_EFCDAB89, 1'b0, 1'b0);

        // Randomized traffic; all-ones words make wraps reachable.
        for (int n = 0; n < 800; n++) begin
            int s, idx, rs;
            bit w, c, i;
            logic [WORD_SIZE-1:0] d;
            s   = $urandom_range(SLOTS - 1);
            idx = $urandom_range(WORDS - 1);
            rs  = $urandom_range(SLOTS - 1);
            c   = ($urandom_range(99) < 4);
            w   = ($urandom_range(99) < 40);
            i   = ($urandom_range(99) < 45);
            d   = ($urandom_range(99) < 30) ? '1 : WORD_SIZE'($urandom);
            step(s, idx, w, d, c, i, rs);
        end

        repeat (4) idle();
        repeat (3) @(posedge clk);
        #3;
        if (sbq.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
